// File: rtl/ahb_output_arbiter_rr.sv
// Round-robin arbiter for one bus-matrix output stage.
// Picks the input stage that owns the slave-side address phase. It keeps
// that grant through fixed-length bursts, BUSY beats and locked sequences.
// It also tracks which input owns the data phase, so responses are steered
// back to the right input.
module ahb_output_arbiter_rr #(
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned PORT_W = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NUM_IN-1:0] req_in,
  input  logic              HREADYM,
  input  logic [1:0]        HTRANSM,
  input  logic [2:0]        HBURSTM,
  input  logic              HMASTLOCKM,
  output logic [PORT_W-1:0] addr_in_port,
  output logic              no_port,
  output logic [PORT_W-1:0] data_in_port,
  output logic              data_valid,
  output logic [NUM_IN-1:0] active_out
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_BUSY   = 2'b01;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  logic [PORT_W-1:0] addr_q, addr_d;
  logic              no_port_q, no_port_d;
  logic [PORT_W-1:0] data_port_q, data_port_d;
  logic              data_valid_q, data_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CNT_W-1:0]  cnt_nxt;
  logic              hold_c;
  logic              found_c;
  logic [PORT_W-1:0] sel_c;

  // Remaining-beat count for the current owner's burst.
  // The count is forced to zero while no input owns the bus.
  always_comb begin
    cnt_nxt = '0;
    case (HTRANSM)
      TRANS_NONSEQ: begin
        case (HBURSTM)
          3'b010, 3'b011: cnt_nxt = CNT_W'(3);
          3'b100, 3'b101: cnt_nxt = CNT_W'(7);
          3'b110, 3'b111: cnt_nxt = CNT_W'(15);
          default:        cnt_nxt = '0;
        endcase
      end
      TRANS_SEQ:  cnt_nxt = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
      TRANS_BUSY: cnt_nxt = cnt_q;
      TRANS_IDLE: cnt_nxt = '0;
      default:    cnt_nxt = '0;
    endcase
    if (no_port_q) cnt_nxt = '0;
  end

  // The current owner keeps the bus while locked, mid-burst or on a BUSY beat.
  always_comb begin
    hold_c = ~no_port_q & (HMASTLOCKM | (cnt_nxt != '0) | (HTRANSM == TRANS_BUSY));
  end

  // Round-robin scan starting one index past the current owner.
  // The current owner is checked last.
  always_comb begin
    found_c = 1'b0;
    sel_c   = addr_q;
    for (int unsigned k = 1; k <= NUM_IN; k++) begin
      int unsigned idx;
      idx = 32'(addr_q) + k;
      if (idx >= NUM_IN) idx = idx - NUM_IN;
      if (!found_c && req_in[IDX_W'(idx)]) begin
        found_c = 1'b1;
        sel_c   = PORT_W'(idx);
      end
    end
  end

  // Next-state: everything advances only on a completed transfer.
  always_comb begin
    addr_d       = addr_q;
    no_port_d    = no_port_q;
    data_port_d  = data_port_q;
    data_valid_d = data_valid_q;
    cnt_d        = cnt_q;
    if (HREADYM) begin
      data_port_d  = addr_q;
      data_valid_d = ~no_port_q;
      cnt_d        = cnt_nxt;
      if (!hold_c) begin
        if (found_c) begin
          addr_d    = sel_c;
          no_port_d = 1'b0;
        end else begin
          // Keep addr_q so the rotation pointer survives an idle period.
          no_port_d = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q       <= '0;
      no_port_q    <= 1'b1;
      data_port_q  <= '0;
      data_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      addr_q       <= addr_d;
      no_port_q    <= no_port_d;
      data_port_q  <= data_port_d;
      data_valid_q <= data_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  // One-hot owner decode, built only from registered state.
  always_comb begin
    active_out = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      active_out[i] = ~no_port_q & (addr_q == PORT_W'(i));
    end
  end

  assign addr_in_port = addr_q;
  assign no_port      = no_port_q;
  assign data_in_port = data_port_q;
  assign data_valid   = data_valid_q;

endmodule

// File: tb/tb_ahb_output_arbiter_rr.sv
// Directed-vector bench for the round-robin output arbiter.
module tb_ahb_output_arbiter_rr;

  localparam logic [1:0] I = 2'b00;
  localparam logic [1:0] B = 2'b01;
  localparam logic [1:0] N = 2'b10;
  localparam logic [1:0] S = 2'b11;

  logic       HCLK;
  logic       HRESETn;
  logic [2:0] req_in;
  logic       HREADYM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic [1:0] data_in_port;
  logic       data_valid;
  logic [2:0] active_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] req;
    logic       rdy;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       lock;
    logic [1:0] e_addr;
    logic       e_nop;
    logic [1:0] e_dport;
    logic       e_dv;
    logic [2:0] e_act;
  } vec_t;

  vec_t vecs[$];

  ahb_output_arbiter_rr #(.NUM_IN(3), .PORT_W(2)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .req_in       (req_in),
    .HREADYM      (HREADYM),
    .HTRANSM      (HTRANSM),
    .HBURSTM      (HBURSTM),
    .HMASTLOCKM   (HMASTLOCKM),
    .addr_in_port (addr_in_port),
    .no_port      (no_port),
    .data_in_port (data_in_port),
    .data_valid   (data_valid),
    .active_out   (active_out)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input logic [2:0] req, input logic rdy, input logic [1:0] trans,
                     input logic [2:0] burst, input logic lock, input logic [1:0] e_addr,
                     input logic e_nop, input logic [1:0] e_dport, input logic e_dv,
                     input logic [2:0] e_act);
    vec_t v;
    v.req = req; v.rdy = rdy; v.trans = trans; v.burst = burst; v.lock = lock;
    v.e_addr = e_addr; v.e_nop = e_nop; v.e_dport = e_dport; v.e_dv = e_dv; v.e_act = e_act;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] req, input logic rdy, input logic [1:0] trans,
                       input logic [2:0] burst, input logic lock);
    req_in = req; HREADYM = rdy; HTRANSM = trans; HBURSTM = burst; HMASTLOCKM = lock;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] a, input logic nop,
                         input logic [1:0] dp, input logic dv, input logic [2:0] act);
    chk({tag, " addr_in_port"}, 32'(addr_in_port), 32'(a));
    chk({tag, " no_port"},      32'(no_port),      32'(nop));
    chk({tag, " data_in_port"}, 32'(data_in_port), 32'(dp));
    chk({tag, " data_valid"},   32'(data_valid),   32'(dv));
    chk({tag, " active_out"},   32'(active_out),   32'(act));
  endtask

  initial begin
    // Reset release, nothing requested.
    for (int k = 0; k < 3; k++) add(3'b000, 1, I, 3'b000, 0, 2'd0, 1, 2'd0, 0, 3'b000);
    // All request, back-to-back singles: rotation 1,2,0,1,2.
    add(3'b111, 1, N, 3'b000, 0, 2'd1, 0, 2'd0, 0, 3'b010);
    add(3'b111, 1, N, 3'b000, 0, 2'd2, 0, 2'd1, 1, 3'b100);
    add(3'b111, 1, N, 3'b000, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    add(3'b111, 1, N, 3'b000, 0, 2'd1, 0, 2'd0, 1, 3'b010);
    add(3'b111, 1, N, 3'b000, 0, 2'd2, 0, 2'd1, 1, 3'b100);
    // Port 1 INCR4: held for four beats, moves to 2 on the last SEQ.
    add(3'b010, 1, N, 3'b000, 0, 2'd1, 0, 2'd2, 1, 3'b010);
    add(3'b111, 1, N, 3'b011, 0, 2'd1, 0, 2'd1, 1, 3'b010);
    add(3'b111, 1, S, 3'b011, 0, 2'd1, 0, 2'd1, 1, 3'b010);
    add(3'b111, 1, S, 3'b011, 0, 2'd1, 0, 2'd1, 1, 3'b010);
    add(3'b111, 1, S, 3'b011, 0, 2'd2, 0, 2'd1, 1, 3'b100);
    // Port 0 owner, wait states freeze everything.
    add(3'b001, 1, N, 3'b000, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    add(3'b001, 0, N, 3'b100, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    add(3'b110, 0, N, 3'b100, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    add(3'b100, 0, N, 3'b100, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    add(3'b100, 1, N, 3'b000, 0, 2'd2, 0, 2'd0, 1, 3'b100);
    // Locked sequence by port 0.
    add(3'b001, 1, N, 3'b000, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    for (int k = 0; k < 5; k++) add(3'b110, 1, N, 3'b000, 1, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b110, 1, N, 3'b000, 0, 2'd1, 0, 2'd0, 1, 3'b010);
    // Port 2 WRAP8 with BUSY, terminated early by IDLE.
    add(3'b100, 1, N, 3'b000, 0, 2'd2, 0, 2'd1, 1, 3'b100);
    add(3'b011, 1, N, 3'b100, 0, 2'd2, 0, 2'd2, 1, 3'b100);
    add(3'b011, 1, S, 3'b100, 0, 2'd2, 0, 2'd2, 1, 3'b100);
    add(3'b011, 1, S, 3'b100, 0, 2'd2, 0, 2'd2, 1, 3'b100);
    add(3'b011, 1, B, 3'b100, 0, 2'd2, 0, 2'd2, 1, 3'b100);
    add(3'b011, 1, I, 3'b100, 0, 2'd0, 0, 2'd2, 1, 3'b001);
    // No requests: bus released, pointer kept at 0.
    add(3'b000, 1, I, 3'b000, 0, 2'd0, 1, 2'd0, 1, 3'b000);
    add(3'b000, 1, I, 3'b000, 0, 2'd0, 1, 2'd0, 0, 3'b000);
    add(3'b001, 1, N, 3'b000, 0, 2'd0, 0, 2'd0, 0, 3'b001);
    // NONSEQ mid-burst reloads the count.
    add(3'b111, 1, N, 3'b011, 0, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b111, 1, S, 3'b011, 0, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b111, 1, N, 3'b011, 0, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b111, 1, S, 3'b011, 0, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b111, 1, S, 3'b011, 0, 2'd0, 0, 2'd0, 1, 3'b001);
    add(3'b111, 1, S, 3'b011, 0, 2'd1, 0, 2'd0, 1, 3'b010);

    // Reset state.
    HRESETn = 1'b0;
    drive(3'b111, 1, N, 3'b000, 0);
    repeat (2) @(posedge HCLK);
    #1 chk_all("reset", 2'd0, 1, 2'd0, 0, 3'b000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(3'b000, 1, I, 3'b000, 0);

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].rdy, vecs[i].trans, vecs[i].burst, vecs[i].lock);
      @(posedge HCLK);
      #1 chk_all($sformatf("v%0d", i), vecs[i].e_addr, vecs[i].e_nop,
                 vecs[i].e_dport, vecs[i].e_dv, vecs[i].e_act);
    end

    // Asynchronous reset in the middle of an INCR8 burst.
    drive(3'b111, 1, N, 3'b101, 0);
    @(posedge HCLK);
    #1 chk_all("burst_start", 2'd1, 0, 2'd1, 1, 3'b010);
    drive(3'b111, 1, S, 3'b101, 0);
    #2 HRESETn = 1'b0;
    #1 chk_all("async_reset", 2'd0, 1, 2'd0, 0, 3'b000);
    @(posedge HCLK);
    #1 chk_all("held_reset", 2'd0, 1, 2'd0, 0, 3'b000);
    @(negedge HCLK);
    HRESETn = 1'b1;
    drive(3'b111, 1, N, 3'b000, 0);
    @(posedge HCLK);
    #1 chk_all("post_reset1", 2'd1, 0, 2'd0, 0, 3'b010);
    @(posedge HCLK);
    #1 chk_all("post_reset2", 2'd2, 0, 2'd1, 1, 3'b100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_output_arbiter_rr.md
Name: ahb_output_arbiter_rr

Overview:
Round-robin arbiter for one bus-matrix output stage. It shares a single slave-side AHB port between NUM_IN input stages.
- Selects which input stage owns the next address phase.
- Holds the grant for fixed-length bursts, BUSY beats and locked sequences.
- Tracks which input owns the data phase, so the output stage can steer the address mux and return response/data to the correct decoder stage (active signals).

Parameters:
NUM_IN, 3, number of input stages (requesters); legal range 2..4
PORT_W, 2, width of port index encodings; must satisfy 2**PORT_W >= NUM_IN

Ports:
HCLK  input  1  AHB system clock
HRESETn  input  1  asynchronous active-low reset
req_in  input  NUM_IN  bit i=1: input stage i has a pending non-IDLE transfer decoded to this output
HREADYM  input  1  slave-side HREADY; transfer completes / arbitration point
HTRANSM  input  2  HTRANS currently driven to slave by granted input
HBURSTM  input  3  HBURST currently driven to slave
HMASTLOCKM  input  1  HMASTLOCK currently driven to slave
addr_in_port  output  PORT_W  index of input owning the address phase
no_port  output  1  1 = no input granted; output stage drives HTRANS=IDLE
data_in_port  output  PORT_W  index of input owning the data phase
data_valid  output  1  1 = data phase belongs to a granted input (data_in_port meaningful)
active_out  output  NUM_IN  one-hot of addr_in_port; all zero when no_port=1

Behaviour:
- Clock and reset: one clock HCLK; reset is asynchronous and active-low on HRESETn.
- Reset values:
  - addr_in_port=0, no_port=1, data_in_port=0, data_valid=0, active_out=0.
  - Beat counter=0.
- All state updates only on rising HCLK with HREADYM=1. With HREADYM=0, every register is frozen regardless of req_in, HTRANSM, HBURSTM or HMASTLOCKM.
- Beat counter cnt[3:0], next value cnt_nxt (combinational):
  - HTRANSM=NONSEQ: load by HBURSTM. WRAP4/INCR4 (010/011) -> 3; WRAP8/INCR8 (100/101) -> 7; WRAP16/INCR16 (110/111) -> 15; SINGLE/INCR (000/001) -> 0.
  - HTRANSM=SEQ and cnt!=0: cnt-1.
  - HTRANSM=BUSY: cnt unchanged.
  - HTRANSM=IDLE: 0 (early burst termination).
  - SEQ with cnt=0 (undefined-length INCR): stays 0.
  - cnt is updated only when no_port=0; otherwise it is forced to 0.
- Hold condition, evaluated at each HREADYM=1 edge while no_port=0: hold = HMASTLOCKM | (cnt_nxt!=0) | (HTRANSM==BUSY).
  - hold=1: addr_in_port and no_port unchanged, even if the holder's req_in bit is 0.
- Arbitration, when not holding:
  - Scan indices addr_in_port+1, +2, … modulo NUM_IN, ending with addr_in_port itself.
  - The first index with req_in set becomes addr_in_port, and no_port becomes 0.
  - If req_in is all zero: no_port becomes 1, and addr_in_port keeps its last value so the rotation pointer is preserved.
  - Grant changes take effect on the edge; the new owner's address phase starts the following cycle.
- Data phase:
  - On each HREADYM=1 edge, data_in_port <= addr_in_port and data_valid <= ~no_port.
  - Latency: data_in_port lags addr_in_port by exactly one completed transfer.
- active_out: combinational from registered state, so it is glitch-free relative to req_in.
- Simultaneous events:
  - HMASTLOCKM=1 overrides the burst count.
  - A NONSEQ arriving while cnt!=0 reloads cnt (new burst by the same owner).
  - A req_in bit dropping for a non-owner takes effect at the next arbitration point.
- Reset mid-burst: immediate return to reset values. The first grant after reset starts the scan at index 1.
- req_in bits at index >= NUM_IN do not exist; encodings >= NUM_IN are never produced.

Test Plan:
1. Reset release, req_in=000, HREADYM=1 for 3 cycles -> no_port=1, active_out=000, addr_in_port=0, data_valid=0 throughout.
2. req_in=111, HTRANSM=NONSEQ, HBURSTM=SINGLE, HREADYM=1 every cycle -> addr_in_port sequence 1,2,0,1,2; data_in_port follows one cycle later; data_valid=1 from second grant edge.
3. Port 1 granted, issues NONSEQ INCR4 then 3 SEQ with req_in=111 -> addr_in_port stays 1 for 4 beats; switches to 2 on the edge completing the last SEQ.
4. Port 0 granted, HREADYM=0 for 3 cycles while req_in changes 001->110->100 -> addr_in_port, data_in_port and no_port unchanged; on HREADYM=1, singles and req_in=100 -> grant 2.
5. Port 0 granted, HMASTLOCKM=1 for 5 SINGLE transfers, req_in=110 -> addr_in_port=0 for all 5; after HMASTLOCKM=0 -> grant 1.
6. Port 2 WRAP8: NONSEQ, 2 SEQ, 1 BUSY (HREADYM=1), then IDLE, req_in=011 -> held through BUSY; on the IDLE edge cnt=0 and grant moves to 0.
